// File: rtl/fmul_pipe.sv
// fmul_pipe: three-stage pipelined floating-point multiplier with
// valid/ready flow control, DAZ/FTZ handling and four rounding modes.
module fmul_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int TAG_W  = 4,
  localparam int DATA_W = 1 + EXP_W + MANT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [1:0]        opc,
  input  logic [1:0]        r_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_val,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  out_tag,
  output logic [3:0]        flags
);
  localparam int SIG_W  = MANT_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int XW     = EXP_W + 2;

  localparam logic [EXP_W-1:0] E_ONES = '1;
  localparam logic [EXP_W-1:0] E_MAXF = E_ONES - 1'b1;
  localparam logic [XW-1:0] BIAS  = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [XW-1:0] X_OVF = {2'b00, E_ONES};
  localparam logic [DATA_W-1:0] QNAN =
    {1'b0, E_ONES, 1'b1, {(MANT_W-1){1'b0}}};

  localparam logic [1:0] OP_INV  = 2'b01;
  localparam logic [1:0] OP_ABS  = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;
  localparam logic [1:0] RM_RNE  = 2'b00;
  localparam logic [1:0] RM_RTZ  = 2'b01;
  localparam logic [1:0] RM_RUP  = 2'b10;
  localparam logic [1:0] RM_RDN  = 2'b11;

  typedef struct packed {
    logic              sign;
    logic [XW-1:0]     exp;
    logic [SIG_W-1:0]  m1;
    logic [SIG_W-1:0]  m2;
    logic              spec;
    logic [DATA_W-1:0] sres;
    logic [3:0]        sflg;
    logic [1:0]        rm;
    logic [TAG_W-1:0]  tag;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic [XW-1:0]     exp;
    logic [PROD_W-1:0] prod;
    logic              spec;
    logic [DATA_W-1:0] sres;
    logic [3:0]        sflg;
    logic [1:0]        rm;
    logic [TAG_W-1:0]  tag;
  } s2_t;

  logic v1, v2, v3;
  logic adv1, adv2, adv3;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic za, zb, ia, ib, na, nb, zinf, snan;

  assign {sa, ea, fa} = op1;
  assign {sb, eb, fb} = op2;

  // exp==0 covers denormals too: they are treated as zero
  assign za   = ea == '0;
  assign zb   = eb == '0;
  assign ia   = (ea == E_ONES) && (fa == '0);
  assign ib   = (eb == E_ONES) && (fb == '0);
  assign na   = (ea == E_ONES) && (fa != '0);
  assign nb   = (eb == E_ONES) && (fb != '0);
  assign zinf = (za && ib) || (ia && zb);
  assign snan = (na && !fa[MANT_W-1]) ||
                (nb && !fb[MANT_W-1]);

  assign adv3    = !v3 || out_rdy;
  assign adv2    = !v2 || adv3;
  assign adv1    = !v1 || adv2;
  assign in_rdy  = adv1 && !rst;
  assign out_val = v3 && !rst;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = sa ^ sb;
    unique case (1'b1)
      opc == OP_INV: s1_d.sign = ~(sa ^ sb);
      opc == OP_ABS: s1_d.sign = 1'b0;
      default: ;
    endcase
    s1_d.exp = {2'b00, ea} + {2'b00, eb} - BIAS;
    s1_d.m1  = {1'b1, fa};
    s1_d.m2  = {1'b1, fb};
    s1_d.rm  = r_mode;
    s1_d.tag = in_tag;
    if (na || nb || zinf) begin
      s1_d.spec = 1'b1;
      s1_d.sres = QNAN;
      s1_d.sflg = {snan || zinf, 3'b000};
    end else if (ia || ib) begin
      s1_d.spec = 1'b1;
      s1_d.sres = {s1_d.sign, E_ONES, {MANT_W{1'b0}}};
    end else if (za || zb) begin
      s1_d.spec = 1'b1;
      s1_d.sres = {s1_d.sign, {(DATA_W-1){1'b0}}};
    end
  end

  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.exp  = s1_q.exp;
    s2_d.prod = {{SIG_W{1'b0}}, s1_q.m1} *
                {{SIG_W{1'b0}}, s1_q.m2};
    s2_d.spec = s1_q.spec;
    s2_d.sres = s1_q.sres;
    s2_d.sflg = s1_q.sflg;
    s2_d.rm   = s1_q.rm;
    s2_d.tag  = s1_q.tag;
  end

  logic              top, guard, sticky;
  logic              inexact, inc, carry, to_inf;
  logic [PROD_W-1:0] pn;
  logic [SIG_W-1:0]  kept;
  logic [SIG_W:0]    rnd;
  logic [XW-1:0]     e_n, e_f;
  logic [DATA_W-1:0] res_d;
  logic [3:0]        flg_d;

  always_comb begin
    top     = s2_q.prod[PROD_W-1];
    pn      = top ? s2_q.prod : s2_q.prod << 1;
    kept    = pn[PROD_W-1 -: SIG_W];
    guard   = pn[MANT_W];
    sticky  = |pn[MANT_W-1:0];
    inexact = guard || sticky;
    e_n     = s2_q.exp + XW'(top);
    inc     = 1'b0;
    to_inf  = 1'b0;
    unique case (s2_q.rm)
      RM_RNE: begin
        inc    = guard && (sticky || kept[0]);
        to_inf = 1'b1;
      end
      RM_RTZ: ;
      RM_RUP: begin
        inc    = inexact && !s2_q.sign;
        to_inf = !s2_q.sign;
      end
      RM_RDN: begin
        inc    = inexact && s2_q.sign;
        to_inf = s2_q.sign;
      end
      default: ;
    endcase
    rnd   = {1'b0, kept} + (SIG_W+1)'(inc);
    carry = rnd[SIG_W];
    e_f   = e_n + XW'(carry);
    res_d = '0;
    flg_d = '0;
    // tininess judged on the normalised exponent before rounding
    if (s2_q.spec) begin
      res_d = s2_q.sres;
      flg_d = s2_q.sflg;
    end else if ($signed(e_n) < $signed(X_ONE)) begin
      res_d = {s2_q.sign, {(DATA_W-1){1'b0}}};
      flg_d = 4'b0011;
    end else if ($signed(e_f) >= $signed(X_OVF)) begin
      flg_d = 4'b0101;
      if (to_inf)
        res_d = {s2_q.sign, E_ONES, {MANT_W{1'b0}}};
      else
        res_d = {s2_q.sign, E_MAXF, {MANT_W{1'b1}}};
    end else begin
      res_d = {s2_q.sign, e_f[EXP_W-1:0], rnd[MANT_W-1:0]};
      flg_d = {3'b000, inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (adv1) v1 <= in_val && (opc != OP_IDLE);
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (in_rdy && in_val) s1_q <= s1_d;
    if (adv2 && v1)       s2_q <= s2_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      out_tag <= '0;
      flags   <= '0;
    end else if (adv3 && v2) begin
      result  <= res_d;
      out_tag <= s2_q.tag;
      flags   <= flg_d;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: scoreboard bench for fmul_pipe with an
// integer-arithmetic reference model and randomized traffic.
module tb_fmul_pipe;
  logic        clk = 1'b0;
  logic        rst, in_val, in_rdy;
  logic        out_val, out_rdy;
  logic [31:0] op1, op2, result;
  logic [1:0]  opc, r_mode;
  logic [3:0]  in_tag, out_tag, flags;

  fmul_pipe #(.EXP_W(8), .MANT_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy),
    .op1(op1), .op2(op2), .opc(opc), .r_mode(r_mode),
    .in_tag(in_tag),
    .out_val(out_val), .out_rdy(out_rdy),
    .result(result), .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Reference: exact integer product, remainder-vs-half rounding
  function automatic void model(
    input  logic [31:0] a, input logic [31:0] b,
    input  logic [1:0]  op, input logic [1:0] rm,
    output logic [31:0] r, output logic [3:0] f);
    logic s, na, nb, ia, ib, za, zb, zinf, up, toinf;
    int ea, eb, be, k, sh;
    longint unsigned p, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if (op == 2'b01) s = ~s;
    else if (op == 2'b10) s = 1'b0;
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    za = ea == 0;
    zb = eb == 0;
    zinf = (za && ib) || (ia && zb);
    r = 32'h0;
    f = 4'h0;
    if (na || nb || zinf) begin
      r = 32'h7FC00000;
      f[3] = (na && !a[22]) || (nb && !b[22]) || zinf;
      return;
    end
    if (ia || ib) begin
      r = {s, 8'hFF, 23'h0};
      return;
    end
    if (za || zb) begin
      r = {s, 31'h0};
      return;
    end
    p = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    k = p[47] ? 47 : 46;
    be = ea + eb - 127 + (k - 46);
    if (be < 1) begin
      r = {s, 31'h0};
      f = 4'b0011;
      return;
    end
    sh   = k - 23;
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    case (rm)
      2'd0:    up = (rem > half) || (rem == half && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = (rem != 0) && !s;
      default: up = (rem != 0) && s;
    endcase
    q = q + 64'(up);
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      be = be + 1;
    end
    if (be >= 255) begin
      f = 4'b0101;
      toinf = (rm == 2'd0) || (rm == 2'd2 && !s) ||
              (rm == 2'd3 && s);
      r = toinf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
      return;
    end
    r = {s, 8'(be), q[22:0]};
    f = {3'b000, rem != 0};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 19);
    if (k < 11) v[30:23] = 8'($urandom_range(100, 154));
    else if (k == 11) v[30:23] = 8'($urandom_range(1, 60));
    else if (k == 12) v[30:23] = 8'($urandom_range(190, 254));
    else if (k == 13) v[30:0] = 31'h0;
    else if (k == 14) v[30:23] = 8'h00;
    else if (k == 15) v[30:0] = {8'hFF, 23'h0};
    else if (k == 16) v[30:22] = 9'h1FF;
    else if (k == 17) begin
      v[30:22] = 9'h1FE;
      v[0] = 1'b1;
    end
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 after acceptance
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [1:0] rm,
                      input logic [3:0] tg,
                      input logic [31:0] er, input logic [3:0] ef);
    int n = 0;
    bit ok = 1;
    in_val = 1'b1;
    op1 = a;
    op2 = b;
    opc = op;
    r_mode = rm;
    in_tag = tg;
    @(negedge clk);
    while (!in_rdy) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL in_rdy_wait: got 0 want 1 (tag %0d)", tg);
        ok = 0;
        break;
      end
      @(negedge clk);
    end
    if (ok && op != 2'b11)
      sbq.push_back('{er, ef, tg, cyc, mode == 0});
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = $urandom_range(0, 3) != 0;
        default: out_rdy = 1'b0;
      endcase
    end
  end

  logic [39:0] held;
  bit          hv = 0;
  exp_t        e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hv = 0;
      end else begin
        if (hv) begin
          chk("hold_val", out_val, 1);
          chk("hold_data", {result, out_tag, flags}, held);
        end
        hv = 0;
        if (out_val) begin
          if (!out_rdy) begin
            hv = 1;
            held = {result, out_tag, flags};
          end else if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out: got tag %0d want none",
                     out_tag);
          end else begin
            e = sbq.pop_front();
            chk("result", result, e.res);
            chk("flags", flags, e.flg);
            chk("tag", out_tag, e.tag);
            if (e.lat) chk("latency", cyc - e.acc, 3);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] a, b, er;
    logic [1:0]  op, rm;
    logic [3:0]  ef;
    int          n;
    rst = 1'b1;
    in_val = 1'b0;
    op1 = '0;
    op2 = '0;
    opc = '0;
    r_mode = '0;
    in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_val", out_val, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_result", result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", flags, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;

    send(32'h3FC00000, 32'h40000000, 0, 0, 5, 32'h40400000, 4'h0);
    send(32'h00000000, 32'h7F800000, 0, 0, 6, 32'h7FC00000, 4'h8);
    send(32'h7F7FFFFF, 32'h40000000, 0, 1, 7, 32'h7F7FFFFF, 4'h5);
    send(32'h7F7FFFFF, 32'h40000000, 0, 0, 8, 32'h7F800000, 4'h5);
    send(32'h3F800000, 32'h3F800000, 1, 0, 9, 32'hBF800000, 4'h0);
    send(32'hBF800000, 32'h40000000, 2, 0, 10, 32'h40000000, 4'h0);
    send(32'h00800000, 32'h3F000000, 0, 0, 11, 32'h00000000, 4'h3);
    send(32'h7F800001, 32'h3F800000, 0, 0, 12, 32'h7FC00000, 4'h8);
    send(32'h7FC00000, 32'h00000000, 0, 0, 13, 32'h7FC00000, 4'h0);
    send(32'hFFC00001, 32'h3F800000, 1, 0, 14, 32'h7FC00000, 4'h0);
    send(32'hFF800000, 32'h40000000, 0, 0, 15, 32'hFF800000, 4'h0);
    send(32'h80000000, 32'h3F800000, 0, 0, 0, 32'h80000000, 4'h0);
    send(32'h3F800001, 32'h3F800001, 0, 0, 1, 32'h3F800002, 4'h1);
    send(32'h3F800001, 32'h3F800001, 0, 2, 2, 32'h3F800003, 4'h1);
    send(32'hBF800001, 32'h3F800001, 0, 3, 3, 32'hBF800003, 4'h1);
    send(32'hFF7FFFFF, 32'h40000000, 0, 2, 4, 32'hFF7FFFFF, 4'h5);
    send(32'h3F800001, 32'h3FC00000, 0, 0, 5, 32'h3FC00002, 4'h1);
    send(32'h3F800001, 32'h3FC00000, 0, 1, 6, 32'h3FC00001, 4'h1);
    send(32'h3FB504F3, 32'h3FB504F3, 0, 2, 7, 32'h40000000, 4'h1);
    send(32'h3FB504F3, 32'h3FB504F3, 0, 0, 8, 32'h3FFFFFFF, 4'h1);
    drain();

    mode = 2;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          a = 32'h3F800000 + 32'(i << 20);
          model(a, 32'h40000000, 0, 0, er, ef);
          send(a, 32'h40000000, 0, 0, 4'(i), er, ef);
        end
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_in_rdy", in_rdy, 0);
        chk("bp_out_val", out_val, 1);
        chk("bp_head_tag", out_tag, 0);
        @(posedge clk);
        #1;
        mode = 0;
      end
    join
    drain();

    send(32'h40000000, 32'h40400000, 0, 0, 1, 32'h40C00000, 4'h0);
    send(32'h40000000, 32'h40400000, 3, 0, 2, 32'h0, 4'h0);
    send(32'h40800000, 32'h3F000000, 0, 0, 3, 32'h40000000, 4'h0);
    send(32'hC0000000, 32'h40000000, 0, 0, 4, 32'hC0800000, 4'h0);
    drain();

    mode = 1;
    for (int i = 0; i < 300; i++) begin
      a  = rnd_op();
      b  = rnd_op();
      op = 2'($urandom_range(0, 3));
      rm = 2'($urandom_range(0, 3));
      model(a, b, op, rm, er, ef);
      send(a, b, op, rm, 4'(i), er, ef);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    mode = 0;
    drain();

    mode = 2;
    for (int i = 0; i < 3; i++)
      send(32'h3F800000, 32'h40000000, 0, 0, 4'(9 + i),
           32'h40000000, 4'h0);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk("mid_rst_out_val", out_val, 0);
    chk("mid_rst_in_rdy", in_rdy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_tag", out_tag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 0;
    n = 0;
    @(negedge clk);
    chk("mid_rst_in_rdy_after", in_rdy, 1);
    repeat (12) begin
      if (out_val) n++;
      @(negedge clk);
    end
    chk("post_rst_outputs", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
